fetch_align_queue: RTL

Parametrised instruction-fetch front end that replaces single-word IF latching with a FIFO_DEPTH-entry word prefetch queue plus a 16-bit realigner. It issues word-aligned bus fetches ahead of decode and extracts 32-bit or compressed (RVC) instructions at any halfword offset, including 32-bit instructions that straddle two words. It presents them to IF/ID through a valid/ready handshake. Redirects (trap, JAL/JALR, branch mispredict, prediction) flush the queue and discard any in-flight bus response.

---
 rtl/fetch_align_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_align_queue.sv
// rtl/fetch_align_queue.sv - word prefetch queue with halfword realigner for RVC fetch
module fetch_align_queue #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o,
  output logic        queue_empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      q_data [FIFO_DEPTH];
  logic [29:0]      q_addr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      fetch_pc;
  logic             align_half, align_nxt;
  logic             discard;

  logic        ack_evt, push, do_pop, issue, slot_free;
  logic        have_instr, pop;
  logic [31:0] cand;
  logic [31:0] h_data;
  logic [29:0] h_addr;
  logic [15:0] n_lo;
  logic        unused_pc_bit;

  assign unused_pc_bit = redirect_pc_i[0];

  assign h_data = q_data[rd_ptr];
  assign h_addr = q_addr[rd_ptr];
  assign n_lo   = q_data[rd_ptr + PTR_W'(1)][15:0];

  // Responses arriving while a discard is pending, or coinciding with a redirect, are dropped.
  assign ack_evt = fetch_req_o & fetch_ack_i;
  assign push    = ack_evt & ~discard & ~redirect_i;

  always_comb begin
    have_instr = 1'b0;
    pop        = 1'b0;
    align_nxt  = align_half;
    cand       = '0;
    if (count != '0) begin
      if (!align_half) begin
        have_instr = 1'b1;
        if (h_data[1:0] != 2'b11) begin
          cand      = {16'h0, h_data[15:0]};
          align_nxt = 1'b1;
        end else begin
          cand = h_data;
          pop  = 1'b1;
        end
      end else if (h_data[17:16] != 2'b11) begin
        have_instr = 1'b1;
        cand       = {16'h0, h_data[31:16]};
        pop        = 1'b1;
        align_nxt  = 1'b0;
      end else if (count >= CNT_W'(2)) begin
        // Straddling 32-bit instruction: low half lives in the upper half of H.
        have_instr = 1'b1;
        cand       = {n_lo, h_data[31:16]};
        pop        = 1'b1;
      end
    end
  end

  assign slot_free = ~instr_valid_o | instr_ready_i;
  assign issue     = have_instr & slot_free & ~redirect_i;
  assign do_pop    = issue & pop;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(do_pop);

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= fetch_data_i;
      q_addr[wr_ptr] <= fetch_addr_o[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_req_o  <= 1'b0;
      fetch_addr_o <= {BOOT_ADDRESS[31:2], 2'b00};
      fetch_pc     <= {BOOT_ADDRESS[31:2], 2'b00};
      discard      <= 1'b0;
    end else begin
      if (ack_evt) begin
        fetch_req_o <= 1'b0;
      end else if (!fetch_req_o && (redirect_i || count < DEPTH_C)) begin
        fetch_req_o  <= 1'b1;
        fetch_addr_o <= redirect_i ? {redirect_pc_i[31:2], 2'b00} : fetch_pc;
      end

      // Only one response can ever be outstanding, so a single pending discard suffices.
      if (ack_evt)
        discard <= 1'b0;
      else if (redirect_i && fetch_req_o)
        discard <= 1'b1;

      if (redirect_i)
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      align_half <= BOOT_ADDRESS[1];
    end else if (redirect_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      align_half <= redirect_pc_i[1];
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      if (issue)
        align_half <= align_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= BOOT_ADDRESS & ~32'h1;
    end else if (redirect_i) begin
      instr_valid_o <= 1'b0;
    end else if (issue) begin
      instr_valid_o <= 1'b1;
      instr_o       <= cand;
      instr_pc_o    <= {h_addr, align_half, 1'b0};
    end else if (slot_free) begin
      instr_valid_o <= 1'b0;
    end
  end

  assign instr_is_compressed_o = (instr_o[1:0] != 2'b11);
  assign queue_empty_o         = (count == '0);

endmodule
